// File: rtl/demux12_4_buf_pkg.sv
// ----------------------------------------------------------------------------
// demux12_4_buf_pkg : shared defaults and slot state encoding for demux12_4_buf
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package demux12_4_buf_pkg;

  localparam int W_DEF  = 4;
  localparam int CW_DEF = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/demux12_4_buf_if.sv
// ----------------------------------------------------------------------------
// demux12_4_buf_if : input stream, two output streams and transfer counters
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface demux12_4_buf_if #(
  parameter int W  = 4,
  parameter int CW = 8
);

  logic          i_s;
  logic [W-1:0]  i_w;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  o_f0;
  logic          o_v0;
  logic          i_rdy0;
  logic [W-1:0]  o_f1;
  logic          o_v1;
  logic          i_rdy1;
  logic [CW-1:0] o_cnt0;
  logic [CW-1:0] o_cnt1;

  modport slave (
    input  i_s, i_w, i_valid, i_rdy0, i_rdy1,
    output o_ready, o_f0, o_v0, o_f1, o_v1, o_cnt0, o_cnt1
  );

  modport master (
    output i_s, i_w, i_valid, i_rdy0, i_rdy1,
    input  o_ready, o_f0, o_v0, o_f1, o_v1, o_cnt0, o_cnt1
  );

endinterface

`default_nettype wire

// File: rtl/demux_slot.sv
// ----------------------------------------------------------------------------
// demux_slot : one-entry holding slot with saturating transfer counter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demux_slot
  import demux12_4_buf_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst,
  input  wire logic          i_load,
  input  wire logic [W-1:0]  i_d,
  input  wire logic          i_rdy,
  output logic               o_v,
  output logic [W-1:0]       o_f,
  output logic [CW-1:0]      o_cnt
);

  localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};

  slot_state_t   r_state;
  logic [W-1:0]  r_f;
  logic [CW-1:0] r_cnt;
  logic          w_xfer;

  assign w_xfer = (r_state == SLOT_FULL) && i_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= SLOT_EMPTY;
      r_f     <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_xfer && (r_cnt != C_CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      case (r_state)
        SLOT_EMPTY: begin
          if (i_load) begin
            r_state <= SLOT_FULL;
            r_f     <= i_d;
          end
        end
        SLOT_FULL: begin
          // A load arriving with a drain replaces the word without a bubble
          if (i_load) begin
            r_f <= i_d;
          end else if (i_rdy) begin
            r_state <= SLOT_EMPTY;
          end
        end
        default: r_state <= SLOT_EMPTY;
      endcase
    end
  end

  assign o_v   = (r_state == SLOT_FULL);
  assign o_f   = r_f;
  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/demux12_4_buf.sv
// ----------------------------------------------------------------------------
// demux12_4_buf : 1-to-2 stream demultiplexer with a holding slot per output
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module demux12_4_buf
  import demux12_4_buf_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst,
  demux12_4_buf_if.slave   bus
);

  logic w_ready;
  logic w_accept;
  logic w_load0;
  logic w_load1;

  // Ready follows whichever slot i_s currently points at, ignoring i_valid
  assign w_ready  = bus.i_s ? (~bus.o_v1 | bus.i_rdy1) : (~bus.o_v0 | bus.i_rdy0);
  assign w_accept = bus.i_valid & w_ready;
  assign w_load0  = w_accept & ~bus.i_s;
  assign w_load1  = w_accept &  bus.i_s;

  assign bus.o_ready = w_ready;

  demux_slot #(.W(W), .CW(CW)) u_slot0 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load0),
    .i_d    (bus.i_w),
    .i_rdy  (bus.i_rdy0),
    .o_v    (bus.o_v0),
    .o_f    (bus.o_f0),
    .o_cnt  (bus.o_cnt0)
  );

  demux_slot #(.W(W), .CW(CW)) u_slot1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load1),
    .i_d    (bus.i_w),
    .i_rdy  (bus.i_rdy1),
    .o_v    (bus.o_v1),
    .o_f    (bus.o_f1),
    .o_cnt  (bus.o_cnt1)
  );

endmodule

`default_nettype wire

// File: doc/demux12_4_buf.md
DEMUX12_4_BUF -- requirements
Module: demux12_4_buf

Interface
REQ-001 Parameter: W, default 4, data width of input and each output.
REQ-002 Parameter: CW, default 8, width of each per-output transfer counter.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_s  input  1  destination select: 0 -> output 0, 1 -> output 1; sampled only on input accept.
REQ-006 i_w  input  W  input data word.
REQ-007 i_valid  input  1  i_w/i_s valid this cycle.
REQ-008 o_ready  output  1  block accepts input this cycle.
REQ-009 o_f0  output  W  output 0 data.
REQ-010 o_v0  output  1  o_f0 valid.
REQ-011 i_rdy0  input  1  output 0 consumer ready.
REQ-012 o_f1  output  W  output 1 data.
REQ-013 o_v1  output  1  o_f1 valid.
REQ-014 i_rdy1  input  1  output 1 consumer ready.
REQ-015 o_cnt0  output  CW  count of completed output-0 transfers.
REQ-016 o_cnt1  output  CW  count of completed output-1 transfers.

Function
REQ-017 Each output N has a one-entry holding slot with states EMPTY (o_vN=0) and FULL (o_vN=1).
REQ-018 o_ready SHALL be combinational: (~o_v0 | i_rdy0) when i_s=0, (~o_v1 | i_rdy1) when i_s=1; independent of i_valid.
REQ-019 Input accept occurs when i_valid & o_ready; on accept, slot i_s loads i_w and goes FULL at the next edge (latency 1 cycle).
REQ-020 Output transfer N occurs when o_vN & i_rdyN; without a simultaneous load into slot N, slot N goes EMPTY at the next edge.
REQ-021 Simultaneous transfer out of and load into slot N: slot stays FULL, o_fN takes new data, no bubble.
REQ-022 o_fN SHALL hold its value while FULL and not transferring; o_fN is don't-care-stable (retains last value) while EMPTY.
REQ-023 The non-selected slot SHALL be unaffected by input traffic; each slot drains independently of the other.
REQ-024 i_s changes while i_valid=1 and o_ready=0 SHALL re-evaluate o_ready combinationally; no data is accepted until o_ready=1.
REQ-025 o_cntN SHALL increment by 1 on each output-N transfer, saturating at 2^CW-1 (255 for default); no wrap.
REQ-026 Maximum throughput: one word per cycle to a single output when its consumer holds i_rdyN=1.
REQ-027 No data reordering or duplication; each accepted word appears exactly once on exactly one output.

Reset
REQ-028 While i_rst=1: o_v0=o_v1=0, o_f0=o_f1=0, o_cnt0=o_cnt1=0, both slots EMPTY, asynchronously.
REQ-029 Reset mid-operation SHALL discard held data; no transfer is counted in the reset cycle.
REQ-030 o_ready MAY be 1 during reset; no input is accepted while i_rst=1.

Structure
REQ-031 Shared package holds W default, CW default, and the slot state encoding (EMPTY=0, FULL=1).
REQ-032 One sub-module, demux_slot, implements a single holding slot plus its saturating counter; instantiated twice.
REQ-033 Top level contains only select decode, o_ready mux, and the two instances.

Verification
REQ-034 Reset, then i_valid=1, i_s=0, i_w=4'hA, i_rdy0=1 -> next cycle o_v0=1, o_f0=4'hA, o_v1=0; following cycle o_cnt0=1.
REQ-035 i_rdy1=0, send 4'h3 to output 1, then second word 4'h5 to output 1 -> o_ready=0 on second, o_f1 stays 4'h3; raise i_rdy1 -> 4'h5 accepted, o_f1=4'h5 next cycle.
REQ-036 Output 1 FULL and stalled, send 4'h7 with i_s=0 -> o_ready=1, o_f0=4'h7 next cycle, o_f1 unchanged.
REQ-037 Back-to-back 4'h1,4'h2,4'h3 to output 0 with i_rdy0=1 -> o_v0=1 for three consecutive cycles, data in order, o_cnt0=3.
REQ-038 300 transfers to output 0 -> o_cnt0=255, o_cnt1=0.
REQ-039 Assert i_rst asynchronously mid-edge while both slots FULL -> o_v0=o_v1=0, counters 0 immediately, before next i_clk edge.
